// File: rtl/bpf_pkg.sv
// Shared definitions for the bandpass FIR stage: default widths, FSM encoding,
// the Q0.15 tap coefficients and the output saturation bounds.
package bpf_pkg;

    function automatic longint sat_max(input int width);
        return (longint'(1) << (width - 1)) - 1;
    endfunction

    function automatic longint sat_min(input int width);
        return -(longint'(1) << (width - 1));
    endfunction

    localparam int LOG2_NTAPS_DEF  = 4;
    localparam int NTAPS_DEF       = 1 << LOG2_NTAPS_DEF;
    localparam int DIN_WL_DEF      = 18;
    localparam int COEF_WL_DEF     = 16;
    localparam int ACC_WL_DEF      = DIN_WL_DEF + COEF_WL_DEF + LOG2_NTAPS_DEF;
    localparam int OUT_SHIFT_DEF   = 15;
    localparam int DOUT_WL_DEF     = 18;

    localparam longint DOUT_MAX_DEF = sat_max(DOUT_WL_DEF);
    localparam longint DOUT_MIN_DEF = sat_min(DOUT_WL_DEF);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_MAC   = 2'd1;
    localparam logic [1:0] ST_FINAL = 2'd2;
    localparam logic [1:0] ST_OUT   = 2'd3;

    // Symmetric (linear-phase) taps; DC gain is 8210/32768.
    localparam logic signed [COEF_WL_DEF-1:0] H_COEF [NTAPS_DEF] = '{
          16'sd256,  -16'sd512, -16'sd1024,   16'sd768,
         16'sd2048,  16'sd1536, -16'sd3072,  16'sd4105,
         16'sd4105, -16'sd3072,  16'sd1536,  16'sd2048,
          16'sd768, -16'sd1024,  -16'sd512,   16'sd256
    };

endpackage

// File: rtl/bpf_coef_rom.sv
// Combinational coefficient ROM indexed by tap number, filled from bpf_pkg.
module bpf_coef_rom
    import bpf_pkg::*;
#(
    parameter int LOG2_NTAPS      = LOG2_NTAPS_DEF,
    parameter int COEF_WORDLENGTH = COEF_WL_DEF
) (
    input  logic        [LOG2_NTAPS-1:0]      addr,
    output logic signed [COEF_WORDLENGTH-1:0] coef
);

    assign coef = COEF_WORDLENGTH'(H_COEF[addr]);

endmodule

// File: rtl/bpf_fir_mac.sv
// Serial single-multiplier FIR: one accepted sample yields one filtered output
// after NTAPS multiply-accumulate cycles, with RTS/RTR handshakes on both sides.
module bpf_fir_mac
    import bpf_pkg::*;
#(
    parameter int LOG2_NTAPS      = LOG2_NTAPS_DEF,
    parameter int DIN_WORDLENGTH  = DIN_WL_DEF,
    parameter int COEF_WORDLENGTH = COEF_WL_DEF,
    parameter int ACC_WORDLENGTH  = ACC_WL_DEF,
    parameter int OUT_SHIFT       = OUT_SHIFT_DEF,
    parameter int DOUT_WORDLENGTH = DOUT_WL_DEF
) (
    input  logic                              CLK,
    input  logic                              RESET,
    input  logic                              FIR_IN_RTS,
    output logic                              FIR_IN_RTR,
    input  logic signed [DIN_WORDLENGTH-1:0]  FIR_IN_DAT,
    output logic                              FIR_OUT_RTS,
    input  logic                              FIR_OUT_RTR,
    output logic signed [DOUT_WORDLENGTH-1:0] FIR_OUT_DAT
);

    localparam int NTAPS           = 1 << LOG2_NTAPS;
    localparam int PROD_WORDLENGTH = DIN_WORDLENGTH + COEF_WORDLENGTH;
    localparam int ROUND_POS       = (OUT_SHIFT > 0) ? OUT_SHIFT - 1 : 0;

    localparam logic signed [ACC_WORDLENGTH-1:0] ROUND_TERM =
        (OUT_SHIFT > 0) ? (ACC_WORDLENGTH'(1) << ROUND_POS) : '0;
    localparam logic signed [ACC_WORDLENGTH-1:0] SAT_HI =
        ACC_WORDLENGTH'(sat_max(DOUT_WORDLENGTH));
    localparam logic signed [ACC_WORDLENGTH-1:0] SAT_LO =
        ACC_WORDLENGTH'(sat_min(DOUT_WORDLENGTH));

    logic        [1:0]                   state;
    logic        [LOG2_NTAPS-1:0]        wptr;
    logic        [LOG2_NTAPS-1:0]        k;
    logic        [LOG2_NTAPS-1:0]        rd_addr;
    logic signed [DIN_WORDLENGTH-1:0]    dline [NTAPS];
    logic signed [DIN_WORDLENGTH-1:0]    tap_sample;
    logic signed [COEF_WORDLENGTH-1:0]   coef;
    logic signed [PROD_WORDLENGTH-1:0]   product;
    logic signed [ACC_WORDLENGTH-1:0]    product_ext;
    logic signed [ACC_WORDLENGTH-1:0]    acc;
    logic signed [ACC_WORDLENGTH-1:0]    rounded;
    logic signed [ACC_WORDLENGTH-1:0]    shifted;
    logic signed [DOUT_WORDLENGTH-1:0]   sat_val;
    logic                                in_xfc;
    logic                                out_xfc;

    assign FIR_IN_RTR  = (state == ST_IDLE) && !RESET;
    assign FIR_OUT_RTS = (state == ST_OUT) && !RESET;
    assign in_xfc      = FIR_IN_RTS && FIR_IN_RTR;
    assign out_xfc     = FIR_OUT_RTS && FIR_OUT_RTR;

    // wptr has already advanced past the newest sample, so x[n-k] sits at wptr-1-k.
    assign rd_addr    = wptr - LOG2_NTAPS'(1) - k;
    assign tap_sample = dline[rd_addr];

    bpf_coef_rom #(
        .LOG2_NTAPS      (LOG2_NTAPS),
        .COEF_WORDLENGTH (COEF_WORDLENGTH)
    ) u_coef_rom (
        .addr (k),
        .coef (coef)
    );

    assign product     = PROD_WORDLENGTH'(tap_sample) * PROD_WORDLENGTH'(coef);
    assign product_ext = {{(ACC_WORDLENGTH - PROD_WORDLENGTH){product[PROD_WORDLENGTH-1]}}, product};

    assign rounded = acc + ROUND_TERM;
    assign shifted = rounded >>> OUT_SHIFT;

    always_comb begin
        sat_val = shifted[DOUT_WORDLENGTH-1:0];
        if (shifted > SAT_HI) begin
            sat_val = SAT_HI[DOUT_WORDLENGTH-1:0];
        end else if (shifted < SAT_LO) begin
            sat_val = SAT_LO[DOUT_WORDLENGTH-1:0];
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state       <= ST_IDLE;
            wptr        <= '0;
            k           <= '0;
            acc         <= '0;
            FIR_OUT_DAT <= '0;
            for (int i = 0; i < NTAPS; i++) begin
                dline[i] <= '0;
            end
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_xfc) begin
                        dline[wptr] <= FIR_IN_DAT;
                        wptr        <= wptr + LOG2_NTAPS'(1);
                        acc         <= '0;
                        k           <= '0;
                        state       <= ST_MAC;
                    end
                end
                ST_MAC: begin
                    acc <= acc + product_ext;
                    k   <= k + LOG2_NTAPS'(1);
                    if (k == LOG2_NTAPS'(NTAPS - 1)) begin
                        state <= ST_FINAL;
                    end
                end
                ST_FINAL: begin
                    FIR_OUT_DAT <= sat_val;
                    state       <= ST_OUT;
                end
                ST_OUT: begin
                    // Output holds here under backpressure; input stays blocked.
                    if (out_xfc) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bpf_fir_mac.sv
// Directed self-checking bench for bpf_fir_mac: impulse, DC, saturation,
// backpressure, throughput and reset-during-MAC scenarios.
module tb_bpf_fir_mac;

    logic               CLK = 1'b0;
    logic               RESET;

    logic               in_rts;
    logic               in_rtr;
    logic signed [17:0] in_dat;
    logic               out_rts;
    logic               out_rtr;
    logic signed [17:0] out_dat;

    logic               sat_in_rts;
    logic               sat_in_rtr;
    logic signed [17:0] sat_in_dat;
    logic               sat_out_rts;
    logic               sat_out_rtr;
    logic signed [17:0] sat_out_dat;

    int compared   = 0;
    int mismatched = 0;

    logic signed [17:0] h_exp [16] = '{
          18'sd256,  -18'sd512, -18'sd1024,   18'sd768,
         18'sd2048,  18'sd1536, -18'sd3072,  18'sd4105,
         18'sd4105, -18'sd3072,  18'sd1536,  18'sd2048,
          18'sd768, -18'sd1024,  -18'sd512,   18'sd256
    };

    always #5 CLK = ~CLK;

    bpf_fir_mac u_dut (
        .CLK         (CLK),
        .RESET       (RESET),
        .FIR_IN_RTS  (in_rts),
        .FIR_IN_RTR  (in_rtr),
        .FIR_IN_DAT  (in_dat),
        .FIR_OUT_RTS (out_rts),
        .FIR_OUT_RTR (out_rtr),
        .FIR_OUT_DAT (out_dat)
    );

    // Unscaled instance so a single large sample drives the output into the clamp.
    bpf_fir_mac #(.OUT_SHIFT(0)) u_dut_sat (
        .CLK         (CLK),
        .RESET       (RESET),
        .FIR_IN_RTS  (sat_in_rts),
        .FIR_IN_RTR  (sat_in_rtr),
        .FIR_IN_DAT  (sat_in_dat),
        .FIR_OUT_RTS (sat_out_rts),
        .FIR_OUT_RTR (sat_out_rtr),
        .FIR_OUT_DAT (sat_out_dat)
    );

    task automatic checkOutput(input string tag, input logic signed [39:0] observed,
                               input logic signed [39:0] expected);
        compared++;
        assert (observed === expected) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic applyStimulus(input int sel, input logic signed [17:0] din);
        bit accepted;
        accepted = 1'b0;
        if (sel == 0) begin
            in_dat = din;
            in_rts = 1'b1;
        end else begin
            sat_in_dat = din;
            sat_in_rts = 1'b1;
        end
        for (int i = 0; i < 200; i++) begin
            @(negedge CLK);
            if ((sel == 0) ? in_rtr : sat_in_rtr) begin
                accepted = 1'b1;
                break;
            end
        end
        checkOutput("in_accept", {39'd0, accepted}, 40'sd1);
        @(posedge CLK);
        #1;
        in_rts     = 1'b0;
        sat_in_rts = 1'b0;
    endtask

    task automatic getOutput(input int sel, output logic signed [17:0] dout);
        bit got;
        got  = 1'b0;
        dout = '0;
        for (int i = 0; i < 200; i++) begin
            @(negedge CLK);
            if ((sel == 0) ? out_rts : sat_out_rts) begin
                dout = (sel == 0) ? out_dat : sat_out_dat;
                got  = 1'b1;
                break;
            end
        end
        checkOutput("out_valid", {39'd0, got}, 40'sd1);
        @(posedge CLK);
        #1;
    endtask

    task automatic pulseReset();
        RESET = 1'b1;
        repeat (2) @(posedge CLK);
        #1;
        RESET = 1'b0;
    endtask

    initial begin
        logic signed [17:0] d;
        int n_acc;
        int acc_c [3];
        int first_rts;
        int bad_dat;
        int bad_rts;
        int bad_rtr;
        int n_out;
        int acc_at;
        bit seen;

        RESET       = 1'b1;
        in_rts      = 1'b0;
        in_dat      = '0;
        out_rtr     = 1'b1;
        sat_in_rts  = 1'b0;
        sat_in_dat  = '0;
        sat_out_rtr = 1'b1;

        repeat (3) @(posedge CLK);
        @(negedge CLK);
        checkOutput("reset_in_rtr", {39'd0, in_rtr}, 40'sd0);
        checkOutput("reset_out_rts", {39'd0, out_rts}, 40'sd0);
        checkOutput("reset_out_dat", out_dat, 40'sd0);
        @(posedge CLK);
        #1;
        RESET = 1'b0;
        @(negedge CLK);
        checkOutput("rtr_after_reset", {39'd0, in_rtr}, 40'sd1);
        @(posedge CLK);
        #1;

        $display("[TB] impulse response");
        for (int i = 0; i < 16; i++) begin
            applyStimulus(0, (i == 0) ? 18'sd32768 : 18'sd0);
            getOutput(0, d);
            checkOutput($sformatf("impulse_h%0d", i), d, h_exp[i]);
        end

        $display("[TB] DC response");
        for (int i = 0; i < 32; i++) begin
            applyStimulus(0, 18'sd1000);
            getOutput(0, d);
            if (i >= 15) begin
                checkOutput($sformatf("dc_out%0d", i), d, 40'sd251);
            end
        end

        $display("[TB] saturation");
        applyStimulus(1, 18'sd131071);
        getOutput(1, d);
        checkOutput("sat_pos", d, 40'sd131071);
        applyStimulus(1, -18'sd131072);
        getOutput(1, d);
        checkOutput("sat_neg", d, -40'sd131072);

        $display("[TB] throughput");
        pulseReset();
        in_dat    = '0;
        in_rts    = 1'b1;
        out_rtr   = 1'b1;
        n_acc     = 0;
        first_rts = -1;
        for (int c = 0; c < 80; c++) begin
            @(negedge CLK);
            if (in_rtr && n_acc < 3) begin
                acc_c[n_acc] = c;
                n_acc++;
            end
            if (out_rts && first_rts < 0) first_rts = c;
            if (n_acc == 3) break;
        end
        checkOutput("tp_accepts", n_acc, 40'sd3);
        checkOutput("tp_period_1", acc_c[1] - acc_c[0], 40'sd19);
        checkOutput("tp_period_2", acc_c[2] - acc_c[1], 40'sd19);
        checkOutput("tp_first_rts", first_rts - acc_c[0], 40'sd18);
        @(posedge CLK);
        #1;
        in_rts = 1'b0;

        $display("[TB] backpressure");
        pulseReset();
        out_rtr = 1'b0;
        applyStimulus(0, 18'sd32768);
        seen = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(negedge CLK);
            if (out_rts) begin
                seen = 1'b1;
                break;
            end
        end
        checkOutput("bp_rts_seen", {39'd0, seen}, 40'sd1);
        @(posedge CLK);
        #1;
        in_rts  = 1'b1;
        in_dat  = 18'sd7;
        bad_dat = 0;
        bad_rts = 0;
        bad_rtr = 0;
        repeat (10) begin
            @(negedge CLK);
            if (out_dat !== 18'sd256) bad_dat++;
            if (out_rts !== 1'b1) bad_rts++;
            if (in_rtr !== 1'b0) bad_rtr++;
        end
        checkOutput("bp_hold_dat", out_dat, 40'sd256);
        checkOutput("bp_dat_unstable_cycles", bad_dat, 40'sd0);
        checkOutput("bp_rts_low_cycles", bad_rts, 40'sd0);
        checkOutput("bp_in_rtr_high_cycles", bad_rtr, 40'sd0);
        @(posedge CLK);
        #1;
        out_rtr = 1'b1;
        n_out   = 0;
        acc_at  = -1;
        for (int c = 0; c < 6; c++) begin
            @(negedge CLK);
            if (out_rts && out_rtr) n_out++;
            if (in_rts && in_rtr && acc_at < 0) acc_at = c;
        end
        checkOutput("bp_out_xfc_count", n_out, 40'sd1);
        checkOutput("bp_accept_delay", acc_at, 40'sd1);
        @(posedge CLK);
        #1;
        in_rts = 1'b0;

        $display("[TB] reset during MAC");
        pulseReset();
        applyStimulus(0, 18'sd32768);
        repeat (7) @(posedge CLK);
        #1;
        RESET = 1'b1;
        @(negedge CLK);
        checkOutput("rst_mid_in_rtr", {39'd0, in_rtr}, 40'sd0);
        checkOutput("rst_mid_out_rts", {39'd0, out_rts}, 40'sd0);
        @(posedge CLK);
        #1;
        RESET   = 1'b0;
        bad_rts = 0;
        for (int c = 0; c < 30; c++) begin
            @(negedge CLK);
            if (c == 0) checkOutput("rst_mid_rtr_release", {39'd0, in_rtr}, 40'sd1);
            if (out_rts) bad_rts++;
        end
        checkOutput("rst_mid_no_output", bad_rts, 40'sd0);
        checkOutput("rst_mid_out_dat", out_dat, 40'sd0);
        @(posedge CLK);
        #1;
        for (int i = 0; i < 16; i++) begin
            applyStimulus(0, (i == 0) ? 18'sd32768 : 18'sd0);
            getOutput(0, d);
            checkOutput($sformatf("rst_impulse_h%0d", i), d, h_exp[i]);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/bpf_fir_mac.md
# bpf_fir_mac

Serial multiply-accumulate FIR filter that forms the narrow bandpass stage of the AM mod/demod datapath. It sits directly downstream of the input FIFO and consumes its 18-bit offset-corrected samples over an RTS/RTR handshake. For each accepted sample it computes one filtered output using a single multiplier over NTAPS cycles. It presents the result to the next stage over the same RTS/RTR handshake.

## Interface
Parameters:
- LOG2_NTAPS, 4: log2 of the tap count; NTAPS = 1<<LOG2_NTAPS = 16.
- DIN_WORDLENGTH, 18: input sample width, Q17.0 signed.
- COEF_WORDLENGTH, 16: coefficient width, Q0.15 signed.
- ACC_WORDLENGTH, 38: accumulator width, DIN + COEF + LOG2_NTAPS.
- OUT_SHIFT, 15: arithmetic right shift applied to the accumulator before output.
- DOUT_WORDLENGTH, 18: output width, Q17.0 signed.

Ports:
- CLK, input, 1: single clock; all state updates on the rising edge.
- RESET, input, 1: synchronous, active-high reset.
- FIR_IN_RTS, input, 1: upstream is ready-to-send.
- FIR_IN_RTR, output, 1: filter is ready-to-receive.
- FIR_IN_DAT, input signed, DIN_WORDLENGTH: input sample.
- FIR_OUT_RTS, output, 1: filter is ready-to-send.
- FIR_OUT_RTR, input, 1: downstream is ready-to-receive.
- FIR_OUT_DAT, output signed, DOUT_WORDLENGTH: filtered sample.

## Operation
- Transfers:
  - in_xfc = FIR_IN_RTS & FIR_IN_RTR.
  - out_xfc = FIR_OUT_RTS & FIR_OUT_RTR.
- Delay line: NTAPS-entry circular register array with a LOG2_NTAPS-bit write pointer.
  - On in_xfc the sample is written at wptr, then wptr increments and wraps modulo NTAPS.
  - Tap k reads x[n-k], at address (wptr_at_accept - k) mod NTAPS.
- State machine:
  - IDLE: FIR_IN_RTR=1. On in_xfc, write the sample, clear acc, set k=0, go to MAC.
  - MAC: acc <= acc + x[n-k]*h[k], then k++. When k = NTAPS-1 is accumulated, go to FINAL.
  - FINAL: FIR_OUT_DAT register <= sat(round(acc)), go to OUT.
  - OUT: FIR_OUT_RTS=1. On out_xfc, go to IDLE.
- FIR_IN_RTR is high only in IDLE and never during RESET. FIR_OUT_RTS is high only in OUT and never during RESET.
- Arithmetic:
  - Products are full precision, DIN+COEF bits, sign-extended into acc. acc cannot overflow at the default widths.
  - Round: acc + (1 << (OUT_SHIFT-1)), then arithmetic shift right by OUT_SHIFT. No rounding term is added when OUT_SHIFT = 0.
  - Saturate: clamp to [-(2^17), 2^17 - 1].
- Backpressure: in OUT with FIR_OUT_RTR low, FIR_OUT_DAT and FIR_OUT_RTS hold. No input is accepted, so no sample is lost; upstream buffers.
- Reset, including mid-MAC or mid-OUT:
  - State returns to IDLE; the partial result is discarded.
  - wptr=0, k=0, acc=0, all delay-line entries=0, FIR_OUT_DAT=0.
  - FIR_IN_RTR=0 and FIR_OUT_RTS=0 while RESET is high.

## Timing
- A sample is accepted at rising edge T.
- MAC occupies cycles T+1 .. T+NTAPS.
- FINAL occupies cycle T+NTAPS+1.
- FIR_OUT_RTS is high from T+NTAPS+2, with FIR_OUT_DAT valid in the same cycle.
- Minimum sample period is NTAPS+3 cycles (19 at default), reached with FIR_OUT_RTR held high: one OUT cycle plus one IDLE cycle.
- First cycle after RESET deasserts: state is IDLE and FIR_IN_RTR=1.
- The coefficient lookup is combinational within the MAC cycle. The multiplier is not pipelined.

## Structure
- Shared package bpf_pkg:
  - Coefficient constant array h[0..NTAPS-1], Q0.15.
  - Default widths.
  - State encoding: IDLE, MAC, FINAL, OUT.
  - Saturation bounds.
- Sub-module bpf_coef_rom: combinational ROM, tap index (LOG2_NTAPS) in, coefficient (COEF_WORDLENGTH) out, populated from the package array.
- Top level contains the delay line, FSM, MAC and round/saturate logic.

## Test plan
- Impulse: feed 32768, then 15 zeros, with FIR_OUT_RTR=1 -> the 16 outputs equal h[0]..h[15] exactly.
- DC: feed constant 1000 for 32 samples -> from output 16 onward, every output equals round(1000·Σh / 32768).
- Saturation, with OUT_SHIFT=0 override and h[0]>0: feed 131071 -> first output is 131071. Feed -131072 -> first output is -131072.
- Backpressure: hold FIR_OUT_RTR low 10 cycles while in OUT, with FIR_IN_RTS=1 -> FIR_OUT_DAT and FIR_OUT_RTS stable, FIR_IN_RTR=0. On release, exactly one out_xfc occurs and the next sample is accepted two cycles later.
- Throughput: continuous RTS/RTR high -> accepts are spaced exactly 19 cycles apart, and the first FIR_OUT_RTS rises 18 cycles after the first accept edge.
- Reset mid-MAC: assert RESET at the MAC cycle where k=7 -> no output is produced and FIR_OUT_DAT=0. After release, the impulse test reproduces h[0]..h[15] with no residue from before the reset.
